ex_lsu_sbuf: RTL

Execute-stage load/store unit with a parametrised store buffer and a valid/ready data-bus handshake, replacing the single-cycle enable-style memory request path. Sits between the execute stage (memop, computed address, rt value) and the data-bus bridge. Computes byte strobes, bus size and alignment exceptions, queues stores, issues loads ahead of non-conflicting stores and returns raw load words to the memory stage.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_store_fifo.sv | 71 +++++++
 rtl/ex_lsu_sbuf.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the execute-stage load/store unit: memop bit positions,
// bus size codes, load FSM states and the store-buffer entry layout.
package lsu_pkg;

  localparam int MOP_LB  = 0;
  localparam int MOP_LBU = 1;
  localparam int MOP_LH  = 2;
  localparam int MOP_LHU = 3;
  localparam int MOP_LW  = 4;
  localparam int MOP_SB  = 5;
  localparam int MOP_SH  = 6;
  localparam int MOP_SW  = 7;
  localparam int MOP_LWL = 8;
  localparam int MOP_LWR = 9;
  localparam int MOP_SWL = 10;
  localparam int MOP_SWR = 11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } ld_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  size;
  } sb_entry_t;

endpackage

// File: rtl/lsu_store_fifo.sv
// Circular store buffer: in-order push/pop, a peek at the two oldest entries,
// and a parallel word-address compare against every valid entry.
module lsu_store_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sb_entry_t              push_data,
  input  logic                   pop,
  input  logic [29:0]            match_addr,
  output sb_entry_t              head,
  output sb_entry_t              head2,
  output logic                   full,
  output logic                   empty,
  output logic                   match,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  sb_entry_t         mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign rd_next = rd_ptr + 1'b1;
  assign head    = mem[rd_ptr];
  assign head2   = mem[rd_next];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i].addr[31:2] == match_addr)) match = 1'b1;
    end
  end

endmodule

// File: rtl/ex_lsu_sbuf.sv
// Execute-stage load/store unit: decodes strobes/size/alignment faults, queues
// stores, lets non-conflicting loads overtake queued stores on a valid/ready bus.
module ex_lsu_sbuf
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int MMOP_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [MMOP_W-1:0] ex_memop_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_rtvalue_i,
  input  logic              ex_has_exc_i,
  input  logic              ex_flush_i,
  output logic              ex_ready_o,
  output logic              ex_adel_o,
  output logic              ex_ades_o,
  output logic              ex_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [31:0]       bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [31:0]       bus_wdata_o,
  output logic [1:0]        bus_size_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              ld_valid_o,
  output logic [31:0]       ld_data_o,
  output logic [1:0]        ld_addr_low_o
);

  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic [1:0]  a;
  logic        is_load, is_store, exc, accept, load_acc, store_acc;
  sb_entry_t   st_entry, st_next, sb_head, sb_head2;
  logic [1:0]  ld_size_c, ld_size;
  logic [31:0] ld_addr;
  logic        sb_full, sb_empty, sb_match, sb_pop;
  logic [CW-1:0] sb_count;
  logic [29:0] match_addr;
  ld_state_t   state, state_next;
  logic        discard, discard_next;
  logic        slot_free, ld_presented, ld_accepted, drop_ld;
  logic        issue_new_ld, issue_pend_ld, issue_ld, st_avail, deliver;

  assign a = ex_addr_i[1:0];

  assign is_load  = ex_memop_i[MOP_LB] | ex_memop_i[MOP_LBU] | ex_memop_i[MOP_LH] |
                    ex_memop_i[MOP_LHU] | ex_memop_i[MOP_LW] | ex_memop_i[MOP_LWL] |
                    ex_memop_i[MOP_LWR];
  assign is_store = ex_memop_i[MOP_SB] | ex_memop_i[MOP_SH] | ex_memop_i[MOP_SW] |
                    ex_memop_i[MOP_SWL] | ex_memop_i[MOP_SWR];

  assign ex_adel_o = ex_valid_i & (((ex_memop_i[MOP_LH] | ex_memop_i[MOP_LHU]) & a[0]) |
                                   (ex_memop_i[MOP_LW] & (a != 2'b00)));
  assign ex_ades_o = ex_valid_i & ((ex_memop_i[MOP_SH] & a[0]) |
                                   (ex_memop_i[MOP_SW] & (a != 2'b00)));

  // Faulting or flushed ops are swallowed without touching the buffer or bus.
  assign exc           = ex_adel_o | ex_ades_o | ex_has_exc_i | ex_flush_i;
  assign ex_ready_o    = ~rst & ex_valid_i & (state == IDLE) & (exc | ~is_store | ~sb_full);
  assign ex_stallreq_o = ex_valid_i & ~ex_ready_o;
  assign accept        = ex_valid_i & ex_ready_o & ~exc;
  assign load_acc      = accept & is_load;
  assign store_acc     = accept & is_store;

  always_comb begin
    st_entry       = '0;
    st_entry.addr  = ex_addr_i;
    st_entry.wstrb = 4'b1111;
    st_entry.wdata = ex_rtvalue_i;
    st_entry.size  = SZ_WORD;
    if (ex_memop_i[MOP_SB]) begin
      st_entry.wstrb = 4'b0001 << a;
      st_entry.wdata = {4{ex_rtvalue_i[7:0]}};
      st_entry.size  = SZ_BYTE;
    end else if (ex_memop_i[MOP_SH]) begin
      st_entry.wstrb = a[1] ? 4'b1100 : 4'b0011;
      st_entry.wdata = {2{ex_rtvalue_i[15:0]}};
      st_entry.size  = SZ_HALF;
    end else if (ex_memop_i[MOP_SWL]) begin
      case (a)
        2'd0: begin st_entry.wstrb = 4'b0001; st_entry.wdata = {4{ex_rtvalue_i[31:24]}}; st_entry.size = SZ_BYTE; end
        2'd1: begin st_entry.wstrb = 4'b0011; st_entry.wdata = {2{ex_rtvalue_i[31:16]}}; st_entry.size = SZ_HALF; end
        2'd2: begin st_entry.wstrb = 4'b0111; st_entry.wdata = {8'b0, ex_rtvalue_i[31:8]}; st_entry.size = SZ_WORD; end
        default: begin st_entry.wstrb = 4'b1111; st_entry.wdata = ex_rtvalue_i; st_entry.size = SZ_WORD; end
      endcase
    end else if (ex_memop_i[MOP_SWR]) begin
      case (a)
        2'd0: begin st_entry.wstrb = 4'b1111; st_entry.wdata = ex_rtvalue_i; st_entry.size = SZ_WORD; end
        2'd1: begin st_entry.wstrb = 4'b1110; st_entry.wdata = {ex_rtvalue_i[23:0], 8'b0}; st_entry.size = SZ_WORD; end
        2'd2: begin st_entry.wstrb = 4'b1100; st_entry.wdata = {2{ex_rtvalue_i[15:0]}}; st_entry.size = SZ_HALF; end
        default: begin st_entry.wstrb = 4'b1000; st_entry.wdata = {4{ex_rtvalue_i[7:0]}}; st_entry.size = SZ_BYTE; end
      endcase
    end
  end

  always_comb begin
    ld_size_c = SZ_WORD;
    if (ex_memop_i[MOP_LB] | ex_memop_i[MOP_LBU])      ld_size_c = SZ_BYTE;
    else if (ex_memop_i[MOP_LH] | ex_memop_i[MOP_LHU]) ld_size_c = SZ_HALF;
    else if (ex_memop_i[MOP_LWL])                      ld_size_c = (a == 2'd0) ? SZ_BYTE : (a == 2'd1) ? SZ_HALF : SZ_WORD;
    else if (ex_memop_i[MOP_LWR])                      ld_size_c = (a == 2'd3) ? SZ_BYTE : (a == 2'd2) ? SZ_HALF : SZ_WORD;
  end

  // In IDLE the hazard check looks at the incoming load, otherwise the held one.
  assign match_addr = (state == IDLE) ? ex_addr_i[31:2] : ld_addr[31:2];

  lsu_store_fifo #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (store_acc),
    .push_data  (st_entry),
    .pop        (sb_pop),
    .match_addr (match_addr),
    .head       (sb_head),
    .head2      (sb_head2),
    .full       (sb_full),
    .empty      (sb_empty),
    .match      (sb_match),
    .count      (sb_count)
  );

  assign slot_free    = ~bus_req_o | bus_ready_i;
  assign ld_presented = bus_req_o & ~bus_wr_o;
  assign ld_accepted  = ld_presented & bus_ready_i;
  assign sb_pop       = bus_req_o & bus_wr_o & bus_ready_i;
  assign drop_ld      = (state == REQ) & ex_flush_i & ld_presented & ~bus_ready_i;

  assign issue_new_ld  = load_acc & ~sb_match & slot_free;
  assign issue_pend_ld = (state == REQ) & ~ld_presented & ~sb_match & ~ex_flush_i & slot_free;
  assign issue_ld      = issue_new_ld | issue_pend_ld;

  // The presented store is always the buffer head, so after a pop the next
  // candidate is the second entry, or a store being pushed right now.
  always_comb begin
    st_avail = 1'b0;
    st_next  = sb_head;
    if (sb_pop) begin
      if (sb_count > CW'(1)) begin
        st_avail = 1'b1;
        st_next  = sb_head2;
      end else if (store_acc) begin
        st_avail = 1'b1;
        st_next  = st_entry;
      end
    end else if (!sb_empty) begin
      st_avail = 1'b1;
      st_next  = sb_head;
    end else if (store_acc) begin
      st_avail = 1'b1;
      st_next  = st_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_wr_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wstrb_o <= '0;
      bus_wdata_o <= '0;
      bus_size_o  <= '0;
    end else if (drop_ld) begin
      bus_req_o <= 1'b0;
    end else if (slot_free) begin
      bus_req_o <= issue_ld | st_avail;
      bus_wr_o  <= ~issue_ld & st_avail;
      if (issue_ld) begin
        bus_addr_o  <= issue_new_ld ? ex_addr_i : ld_addr;
        bus_wstrb_o <= 4'b0000;
        bus_wdata_o <= '0;
        bus_size_o  <= issue_new_ld ? ld_size_c : ld_size;
      end else if (st_avail) begin
        bus_addr_o  <= st_next.addr;
        bus_wstrb_o <= st_next.wstrb;
        bus_wdata_o <= st_next.wdata;
        bus_size_o  <= st_next.size;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      ld_addr <= '0;
      ld_size <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (load_acc) begin
        ld_addr <= ex_addr_i;
        ld_size <= ld_size_c;
      end
    end
  end

  always_comb begin
    state_next   = state;
    discard_next = discard;
    case (state)
      IDLE: if (load_acc) state_next = REQ;
      REQ: begin
        if (ld_accepted) begin
          state_next   = WAIT;
          discard_next = ex_flush_i;
        end else if (ex_flush_i) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          state_next   = IDLE;
          discard_next = 1'b0;
        end else if (ex_flush_i) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign deliver = (state == WAIT) & bus_rvalid_i & ~discard & ~ex_flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_valid_o    <= 1'b0;
      ld_data_o     <= '0;
      ld_addr_low_o <= '0;
    end else begin
      ld_valid_o <= deliver;
      if (deliver) begin
        ld_data_o     <= bus_rdata_i;
        ld_addr_low_o <= ld_addr[1:0];
      end
    end
  end

endmodule
